// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the five-stage MIPS core.
//
// Merges per-stage stall requests into a 6-bit hold vector, sequences
// exception/ERET redirects through a request/ack handshake followed by a
// single FLUSH cycle, counts stalled cycles and optionally runs a stall
// watchdog (build with STALL_WATCHDOG_EN defined).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stallreq_id/ex/mem   per-stage stall requests (priority mem > ex > id)
//   excp_req             exception/ERET pending, held until excp_ack
//   excp_is_eret         1 = ERET (redirect to epc), 0 = exception (excp_vector)
//   excp_vector, epc     redirect candidates
//   excp_ack             combinational pulse in the accept cycle
//   stall[5:0]           PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB hold (combinational)
//   flush                high for the one FLUSH cycle after an accept
//   new_pc               registered redirect target, holds after flush
//   stall_cycles         saturating count of cycles with any stall bit set
//   stall_timeout        sticky watchdog flag (constant 0 without the macro)
module pipeline_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_req,
    input  logic        excp_is_eret,
    input  logic [31:0] excp_vector,
    input  logic [31:0] epc,
    output logic        excp_ack,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Elaboration-time range check on the watchdog threshold.
    if (STALL_TIMEOUT < 1 || STALL_TIMEOUT > 65535) begin : g_bad_timeout
        $error("pipeline_ctrl: STALL_TIMEOUT must be in 1..65535");
    end

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  new_pc_q, new_pc_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [STALL_W-1:0] stall_c;
    logic               ack_c;

    // Next-state, stall merge, accept decision and stall statistics.
    always_comb begin
        state_d        = state_q;
        new_pc_d       = new_pc_q;
        stall_c        = '0;
        ack_c          = 1'b0;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            ST_RUN: begin
                if (stallreq_mem) begin
                    stall_c = 6'b011111;
                end else if (stallreq_ex) begin
                    stall_c = 6'b001111;
                end else if (stallreq_id) begin
                    stall_c = 6'b000111;
                end
                // A MEM bus wait blocks the accept; the request stays pending.
                if (excp_req && !stallreq_mem) begin
                    ack_c    = 1'b1;
                    new_pc_d = excp_is_eret ? epc : excp_vector;
                    state_d  = ST_FLUSH;
                end
            end
            default: begin
                // FLUSH ignores every request and always returns to RUN.
                state_d = ST_RUN;
            end
        endcase

        if (stall_c != '0 && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            new_pc_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            new_pc_q       <= new_pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

`ifdef STALL_WATCHDOG_EN
    localparam int unsigned WD_W = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_trip_q, wd_trip_d;

    // Consecutive-stall run counter, saturating at the threshold; sticky trip.
    always_comb begin
        wd_cnt_d  = '0;
        wd_trip_d = wd_trip_q;
        if (stall_c != '0) begin
            wd_cnt_d = (wd_cnt_q != WD_LIMIT) ? wd_cnt_q + WD_W'(1) : wd_cnt_q;
        end
        if (wd_cnt_d == WD_LIMIT) begin
            wd_trip_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign stall_timeout = wd_trip_q;
`else
    assign stall_timeout = 1'b0;
`endif

    assign stall        = stall_c;
    assign excp_ack     = ack_c;
    assign flush        = (state_q == ST_FLUSH);
    assign new_pc       = new_pc_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized self-checking bench for
// pipeline_ctrl, instantiated with STALL_TIMEOUT=4. Expected values come from a
// cycle-level behavioural model of the controller's rules.
module tb_pipeline_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_req, excp_is_eret;
    logic [31:0] excp_vector, epc;
    logic        excp_ack;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_flush;
    logic [31:0] m_pc;
    longint      m_cnt;
    int          m_run;
    bit          m_trip;

    pipeline_ctrl #(.STALL_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_req     (excp_req),
        .excp_is_eret (excp_is_eret),
        .excp_vector  (excp_vector),
        .epc          (epc),
        .excp_ack     (excp_ack),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                         input bit req, input bit eret,
                         input logic [31:0] vec, input logic [31:0] ret);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        excp_req = req; excp_is_eret = eret; excp_vector = vec; epc = ret;
        #1;
    endtask

    // Number of stages held, counted from the PC end, for the current inputs.
    function automatic int held_stages();
        if (m_flush)      return 0;
        if (stallreq_mem) return 5;
        if (stallreq_ex)  return 4;
        if (stallreq_id)  return 3;
        return 0;
    endfunction

    function automatic logic [5:0] exp_stall();
        return 6'((1 << held_stages()) - 1);
    endfunction

    function automatic bit exp_ack();
        return !m_flush && excp_req && !stallreq_mem;
    endfunction

    task automatic check_model(input string ctx);
        chk({ctx, ".stall"},   32'(stall),         32'(exp_stall()));
        chk({ctx, ".ack"},     32'(excp_ack),      32'(exp_ack()));
        chk({ctx, ".flush"},   32'(flush),         32'(m_flush));
        chk({ctx, ".new_pc"},  new_pc,             m_pc);
        chk({ctx, ".cycles"},  stall_cycles,       m_cnt[31:0]);
        chk({ctx, ".timeout"}, 32'(stall_timeout), 32'(m_trip));
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit          stalled;
        bit          acc;
        logic [31:0] tgt;
        stalled = (held_stages() != 0);
        acc     = exp_ack();
        tgt     = excp_is_eret ? epc : excp_vector;
        @(posedge clk);
        if (rst) begin
            m_flush = 0; m_pc = '0; m_cnt = 0; m_run = 0; m_trip = 0;
        end else begin
            if (stalled && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (acc) m_pc = tgt;
            m_flush = acc;
`ifdef STALL_WATCHDOG_EN
            m_run = stalled ? ((m_run < TIMEOUT) ? m_run + 1 : m_run) : 0;
            if (m_run == TIMEOUT) m_trip = 1;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        bit wd_on;
`ifdef STALL_WATCHDOG_EN
        wd_on = 1;
`else
        wd_on = 0;
`endif
        m_flush = 0; m_pc = '0; m_cnt = 0; m_run = 0; m_trip = 0;

        // Reset
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0);
        check_model("reset");
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.new_pc", new_pc, 32'h0);

        // Stall priority and statistics
        drive(0, 1, 1, 0, 0, 0, '0, '0);
        check_model("idex");
        chk("idex.stall", 32'(stall), 32'h0F);
        tick();
        drive(0, 1, 0, 0, 0, 0, '0, '0);
        check_model("id");
        chk("id.stall", 32'(stall), 32'h07);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0);
        check_model("none");
        chk("none.stall", 32'(stall), 32'h00);
        tick();
        check_model("cnt");
        chk("cnt.two", stall_cycles, 32'd2);

        // Exception accept, flush, return to run
        drive(0, 0, 0, 0, 1, 0, 32'hBFC00380, 32'h0);
        check_model("exc.acc");
        chk("exc.ack", 32'(excp_ack), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'hBFC00380, 32'h0);
        check_model("exc.flush");
        chk("exc.flush1", 32'(flush), 32'h1);
        chk("exc.pc", new_pc, 32'hBFC00380);
        tick();
        check_model("exc.run");
        chk("exc.flush0", 32'(flush), 32'h0);
        chk("exc.pc_hold", new_pc, 32'hBFC00380);

        // Request blocked by MEM stall for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 0, 32'h8000_0180, 32'h0);
            check_model("blk");
            chk("blk.ack", 32'(excp_ack), 32'h0);
            chk("blk.stall", 32'(stall), 32'h1F);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 32'h8000_0180, 32'h0);
        check_model("blk.rel");
        chk("blk.ack4", 32'(excp_ack), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_model("blk.flush");
        chk("blk.flush5", 32'(flush), 32'h1);
        tick();

        // ERET with EX stall requested during FLUSH
        drive(0, 0, 0, 0, 1, 1, 32'hBFC00380, 32'h80001234);
        check_model("eret.acc");
        tick();
        drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h80001234);
        check_model("eret.flush");
        chk("eret.stall0", 32'(stall), 32'h0);
        chk("eret.pc", new_pc, 32'h80001234);
        tick();
        check_model("eret.run");
        chk("eret.stallex", 32'(stall), 32'h0F);
        tick();

        // Reset during FLUSH discards the redirect
        drive(0, 0, 0, 0, 1, 0, 32'h1234_5678, 32'h0);
        check_model("rstf.acc");
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("rstf.flush", 32'(flush), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_model("rstf.after");
        chk("rstf.flush0", 32'(flush), 32'h0);
        chk("rstf.cycles", stall_cycles, 32'h0);
        chk("rstf.pc", new_pc, 32'h0);

        // Watchdog: MEM stall held for TIMEOUT cycles, then dropped
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
            check_model("wd.hold");
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_model("wd.drop");
        chk("wd.flag", 32'(stall_timeout), 32'(wd_on));
        tick();
        check_model("wd.sticky");
        chk("wd.sticky", 32'(stall_timeout), 32'(wd_on));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 79) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom, $urandom);
            check_model("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception/ERET flushes through a request/acknowledge handshake and a one-cycle flush state. It also keeps stall statistics and an optional stall watchdog.

## Interface
Parameters:
- STALL_TIMEOUT, 1023: consecutive stalled cycles before the watchdog trips; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  ID stage stall request (load-use hazard)
- stallreq_ex  in  1  EX stage stall request (multi-cycle mult/div)
- stallreq_mem  in  1  MEM stage stall request (bus wait)
- excp_req  in  1  exception or ERET pending; held by requester until acked
- excp_is_eret  in  1  qualifies excp_req: 1 = ERET, 0 = exception
- excp_vector  in  32  handler address, used when excp_is_eret=0
- epc  in  32  return address, used when excp_is_eret=1
- excp_ack  out  1  one-cycle pulse: request accepted this cycle
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold
- flush  out  1  clear all inter-stage registers and load new_pc into the PC
- new_pc  out  32  redirect target, valid while flush=1
- stall_cycles  out  32  saturating count of cycles with stall≠0
- stall_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: RUN and FLUSH. Reset state is RUN.
- In RUN, stall is combinational with priority mem > ex > id:
  - stallreq_mem → 6'b011111
  - stallreq_ex → 6'b001111
  - stallreq_id → 6'b000111
  - no request → 6'b000000
- Accept rule: in RUN, when excp_req=1 and stallreq_mem=0:
  - Drive excp_ack=1 that cycle.
  - Register new_pc ← excp_is_eret ? epc : excp_vector.
  - Go to FLUSH.
- If excp_req and stallreq_mem are both 1, the request is not acked and stays pending. Stall follows the normal priority rule.
- The accept cycle still outputs the normal stall vector; the younger stages are cleared by the flush that follows.
- In FLUSH:
  - flush=1, stall=6'b000000, excp_ack=0.
  - All stallreq_* and excp_req inputs are ignored.
  - Next state is unconditionally RUN.
- excp_req held high after its ack cycle is treated as a new request once back in RUN. The requester must drop excp_req on ack.
- stall_cycles: +1 on every cycle with stall≠0; saturates at 32'hFFFFFFFF, no wrap.

## Timing
- Reset values: stall=0, flush=0, excp_ack=0, new_pc=32'h0, stall_cycles=0, stall_timeout=0, state RUN, watchdog counter 0.
- Stall latency: 0 cycles (combinational from the requests).
- Flush latency: excp_ack in cycle n, flush=1 in cycle n+1 only, RUN again in n+2.
- new_pc holds its last value after flush drops.
- Back-to-back exceptions: minimum spacing is 2 cycles (ack, flush).
- Reset asserted in FLUSH: returns to RUN with flush=0 on the next edge. The pending redirect is discarded.

## Configuration
- STALL_WATCHDOG_EN defined:
  - A 16-bit run counter increments on each cycle with stall≠0 and clears on any cycle with stall=0.
  - When the counter equals STALL_TIMEOUT, stall_timeout is set and remains 1 until rst.
  - The counter saturates at STALL_TIMEOUT.
- STALL_WATCHDOG_EN undefined: the run counter is not built and stall_timeout is constant 0.

## Test plan
- stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111 same cycle. Drop ex → 6'b000111. Drop id → 0. stall_cycles=2 after these three cycles.
- excp_req=1, excp_is_eret=0, excp_vector=32'hBFC00380, no stalls → excp_ack in cycle n; cycle n+1 flush=1, stall=0, new_pc=32'hBFC00380; cycle n+2 flush=0.
- excp_req=1 with stallreq_mem=1 for 3 cycles → no ack, stall=6'b011111 throughout. stallreq_mem drops in cycle 4 → ack in cycle 4, flush in cycle 5.
- ERET with epc=32'h80001234 while stallreq_ex=1 during the FLUSH cycle → stall=0 in FLUSH, new_pc=32'h80001234. stall=6'b001111 resumes the next cycle.
- rst asserted in the FLUSH cycle → next cycle flush=0, stall_cycles=0, new_pc=0.
- With STALL_WATCHDOG_EN and STALL_TIMEOUT=4: stallreq_mem held 4 cycles → stall_timeout=1 stays set after the request drops. Without the macro, the same stimulus leaves stall_timeout=0.
